// File: rtl/trap_ctrl_pkg.sv
// instructions: shared CSR view types plus trap sequencer constants and state enum
package instructions;
    typedef struct packed {
        logic [18:0] hi;
        logic [1:0]  mpp;
        logic [2:0]  rsv_10_8;
        logic        mpie;
        logic [2:0]  rsv_6_4;
        logic        mie;
        logic [2:0]  rsv_2_0;
    } mstatus_t;
    typedef struct packed {
        logic [29:0] base;
        logic [1:0]  mode;
    } mtvec_t;
    typedef enum logic [1:0] {PRIV_U = 2'd0, PRIV_S = 2'd1, PRIV_M = 2'd3} privilege_t;
    localparam logic [4:0]  CAUSE_MSI  = 5'd3;
    localparam logic [4:0]  CAUSE_MTI  = 5'd7;
    localparam logic [4:0]  CAUSE_MEI  = 5'd11;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [31:0] IRQ_MASK   = 32'h0000_0888;
    typedef enum logic [2:0] {IDLE, ARM, ENTER, CAUSE, REDIR, RET} trap_state_t;
endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: CSR-file views in, CSR strobes/write port and fetch redirect out
//   master: trap_ctrl side (drives irq_req, interrupt, return_from_interrupt, csr_*, redirect_*, busy)
//   slave:  core/CSR-file/fetch side
interface trap_ctrl_if;
    import instructions::*;
    mstatus_t    mstatus;
    logic [31:0] mie;
    logic [31:0] mip;
    mtvec_t      mtvec;
    logic [31:0] mepc;
    privilege_t  privilege;
    logic        boundary;
    logic        mret;
    logic        redirect_ready;
    logic        irq_req;
    logic        interrupt;
    logic        return_from_interrupt;
    logic        csr_wr;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    modport master (
        input  mstatus, mie, mip, mtvec, mepc, privilege, boundary, mret, redirect_ready,
        output irq_req, interrupt, return_from_interrupt, csr_wr, csr_addr, csr_wdata,
               redirect_valid, redirect_pc, busy
    );
    modport slave (
        output mstatus, mie, mip, mtvec, mepc, privilege, boundary, mret, redirect_ready,
        input  irq_req, interrupt, return_from_interrupt, csr_wr, csr_addr, csr_wdata,
               redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_ctrl_irq_prio.sv
// irq_prio: fixed-priority encoder MEI > MSI > MTI over the pending vector
//   p in 32 pending vector; valid out 1 any source pending; cause out 5 winning code
module irq_prio
    import instructions::*;
(
    input  logic [31:0] p,
    output logic        valid,
    output logic [4:0]  cause
);
    logic unused;
    assign unused = ^p;
    assign valid  = p[11] | p[3] | p[7];
    assign cause  = p[11] ? CAUSE_MEI : p[3] ? CAUSE_MSI : p[7] ? CAUSE_MTI : 5'd0;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / MRET sequencer in front of the CSR file
//   clk, rst_n (async active-low); bus: trap_ctrl_if.master
//   RESET_PC: redirect_pc out of reset; optional TRAP_VECTORED_EN enables mtvec vectored mode
module trap_ctrl
    import instructions::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst_n,
    trap_ctrl_if.master bus
);
    trap_state_t state, state_n;
    logic [4:0]  cause, cause_n, win;
    logic [31:0] rpc, rpc_n, handler;
    logic        pend, take, unused;
    irq_prio u_prio (.p(bus.mip & bus.mie & IRQ_MASK), .valid(pend), .cause(win));
    assign take = pend & (bus.mstatus.mie | (bus.privilege != PRIV_M));
`ifdef TRAP_VECTORED_EN
    assign handler = {bus.mtvec.base, 2'b00} + ((bus.mtvec.mode == 2'b01) ? {25'b0, cause, 2'b00} : 32'd0);
`else
    assign handler = {bus.mtvec.base, 2'b00};
`endif
    assign unused = ^{bus.mstatus, bus.mtvec, bus.mepc[1:0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cause <= 5'd0;
            rpc   <= RESET_PC;
        end else begin
            state <= state_n;
            cause <= cause_n;
            rpc   <= rpc_n;
        end
    end
    always_comb begin
        state_n = state;
        cause_n = cause;
        rpc_n   = rpc;
        case (state)
            IDLE:  state_n = (bus.boundary && bus.mret) ? RET : take ? ARM : IDLE;
            ARM: if (bus.boundary) begin
                state_n = take ? ENTER : IDLE;
                cause_n = take ? win : cause;
            end
            ENTER: state_n = CAUSE;
            CAUSE: begin
                state_n = REDIR;
                rpc_n   = handler;
            end
            REDIR: state_n = bus.redirect_ready ? IDLE : REDIR;
            RET: begin
                state_n = REDIR;
                rpc_n   = {bus.mepc[31:2], 2'b00};
            end
            default: state_n = IDLE;
        endcase
    end
    assign bus.irq_req               = state == ARM;
    assign bus.interrupt             = state == ENTER;
    assign bus.return_from_interrupt = state == RET;
    assign bus.csr_wr                = state == CAUSE;
    assign bus.csr_addr              = bus.csr_wr ? CSR_MCAUSE : 12'd0;
    assign bus.csr_wdata             = bus.csr_wr ? {1'b1, 26'b0, cause} : 32'd0;
    assign bus.redirect_valid        = state == REDIR;
    assign bus.redirect_pc           = rpc;
    assign bus.busy                  = state != IDLE;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven trap scenarios plus MRET, withdrawal and reset corner sequences
module tb_trap_ctrl;
    import instructions::*;
    localparam logic [31:0] RPC = 32'hDEAD_BEE0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    trap_ctrl_if bus();
    trap_ctrl #(.RESET_PC(RPC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [31:0] q_wdata[$];
    logic [31:0] q_pc[$];
    typedef struct {
        logic [31:0] mip;
        logic [31:0] mie;
        logic        gie;
        privilege_t  priv;
        logic [31:0] mtvec;
        logic        take;
        logic [4:0]  cause;
    } vec_t;
    vec_t vecs[9];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] handler(input logic [31:0] tv, input logic [4:0] c);
`ifdef TRAP_VECTORED_EN
        if (tv[1:0] == 2'b01) return {tv[31:2], 2'b00} + 32'(c) * 4;
`endif
        return {tv[31:2], 2'b00};
    endfunction
    always @(negedge clk) if (rst_n) begin
        if (bus.csr_wr) begin
            if (q_wdata.size() == 0) chk("csr_wr unexpected", {31'b0, bus.csr_wr}, 32'd0);
            else begin
                chk("csr_addr", {20'b0, bus.csr_addr}, 32'h342);
                chk("csr_wdata", bus.csr_wdata, q_wdata.pop_front());
            end
        end else begin
            chk("csr idle zero", {20'b0, bus.csr_addr} | bus.csr_wdata, 32'd0);
        end
        if (bus.redirect_valid && bus.redirect_ready) begin
            if (q_pc.size() == 0) chk("redirect unexpected", {31'b0, bus.redirect_valid}, 32'd0);
            else chk("redirect_pc", bus.redirect_pc, q_pc.pop_front());
        end
    end
    task automatic set_in(input vec_t v);
        bus.mip = v.mip;
        bus.mie = v.mie;
        bus.mstatus = '0;
        bus.mstatus.mie = v.gie;
        bus.privilege = v.priv;
        bus.mtvec = v.mtvec;
    endtask
    task automatic apply(input vec_t v);
        set_in(v);
        bus.boundary = 1'b1;
        bus.mret = 1'b0;
        bus.redirect_ready = 1'b1;
        if (v.take) begin
            q_wdata.push_back({1'b1, 26'b0, v.cause});
            q_pc.push_back(handler(v.mtvec, v.cause));
        end
        tick; chk("irq_req c1", {31'b0, bus.irq_req}, {31'b0, v.take});
        tick; chk("interrupt c2", {31'b0, bus.interrupt}, {31'b0, v.take});
        bus.mip = 32'd0;
        tick; chk("csr_wr c3", {31'b0, bus.csr_wr}, {31'b0, v.take});
        tick; chk("redirect_valid c4", {31'b0, bus.redirect_valid}, {31'b0, v.take});
        tick; chk("busy end", {31'b0, bus.busy}, 32'd0);
        bus.boundary = 1'b0;
    endtask
    initial begin
        vecs[0] = '{32'h080, 32'h080, 1'b1, PRIV_M, 32'h100, 1'b1, 5'd7};
        vecs[1] = '{32'h888, 32'h888, 1'b1, PRIV_M, 32'h201, 1'b1, 5'd11};
        vecs[2] = '{32'h008, 32'h008, 1'b0, PRIV_M, 32'h100, 1'b0, 5'd0};
        vecs[3] = '{32'h008, 32'h008, 1'b0, PRIV_U, 32'h100, 1'b1, 5'd3};
        vecs[4] = '{32'h088, 32'h088, 1'b1, PRIV_M, 32'h301, 1'b1, 5'd3};
        vecs[5] = '{32'h888, 32'h080, 1'b1, PRIV_M, 32'h400, 1'b1, 5'd7};
        vecs[6] = '{32'h800, 32'h000, 1'b1, PRIV_M, 32'h100, 1'b0, 5'd0};
        vecs[7] = '{32'h010, 32'h010, 1'b1, PRIV_M, 32'h100, 1'b0, 5'd0};
        vecs[8] = '{32'h800, 32'h800, 1'b0, PRIV_S, 32'h501, 1'b1, 5'd11};
        bus.mip = 0; bus.mie = 0; bus.mstatus = '0; bus.mtvec = '0; bus.mepc = 0;
        bus.privilege = PRIV_M; bus.boundary = 0; bus.mret = 0; bus.redirect_ready = 0;
        #12;
        chk("reset redirect_pc", bus.redirect_pc, RPC);
        chk("reset strobes", {26'b0, bus.irq_req, bus.interrupt, bus.return_from_interrupt,
            bus.csr_wr, bus.redirect_valid, bus.busy}, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("handler 0x888 vector", handler(32'h201, 5'd11),
`ifdef TRAP_VECTORED_EN
            32'h22C);
`else
            32'h200);
`endif
        foreach (vecs[i]) apply(vecs[i]);
        bus.mstatus.mie = 1'b1; bus.privilege = PRIV_M;
        bus.mip = 32'h80; bus.mie = 32'h80; bus.boundary = 1'b0;
        tick; chk("arm irq_req", {31'b0, bus.irq_req}, 32'd1);
        bus.mip = 32'd0;
        tick; chk("arm hold", {31'b0, bus.irq_req}, 32'd1);
        bus.boundary = 1'b1;
        tick; chk("withdraw busy", {31'b0, bus.busy}, 32'd0);
        chk("withdraw interrupt", {31'b0, bus.interrupt}, 32'd0);
        tick; chk("withdraw quiet", {31'b0, bus.interrupt | bus.irq_req}, 32'd0);
        bus.mepc = 32'h1236; bus.mret = 1'b1; bus.redirect_ready = 1'b0;
        q_pc.push_back(32'h1234);
        tick; chk("mret rfi", {31'b0, bus.return_from_interrupt}, 32'd1);
        bus.boundary = 1'b0; bus.mret = 1'b0;
        tick; chk("mret rfi once", {31'b0, bus.return_from_interrupt}, 32'd0);
        chk("mret valid 1", {31'b0, bus.redirect_valid}, 32'd1);
        chk("mret pc 1", bus.redirect_pc, 32'h1234);
        tick; chk("mret valid 2", {31'b0, bus.redirect_valid}, 32'd1);
        chk("mret pc 2", bus.redirect_pc, 32'h1234);
        tick; chk("mret valid 3", {31'b0, bus.redirect_valid}, 32'd1);
        bus.redirect_ready = 1'b1;
        tick; chk("mret done", {31'b0, bus.redirect_valid | bus.busy}, 32'd0);
        bus.mip = 32'h80; bus.mie = 32'h80; bus.mepc = 32'h2000;
        bus.boundary = 1'b1; bus.mret = 1'b1;
        q_pc.push_back(32'h2000);
        tick; chk("tie rfi", {31'b0, bus.return_from_interrupt}, 32'd1);
        chk("tie no irq_req", {31'b0, bus.irq_req}, 32'd0);
        bus.mip = 32'd0; bus.boundary = 1'b0; bus.mret = 1'b0;
        tick; chk("tie redirect", {31'b0, bus.redirect_valid}, 32'd1);
        tick; chk("tie idle", {31'b0, bus.busy}, 32'd0);
        set_in(vecs[0]);
        bus.boundary = 1'b1;
        q_wdata.push_back(32'h8000_0007);
        tick; tick; tick;
        chk("pre-reset csr_wr", {31'b0, bus.csr_wr}, 32'd1);
        rst_n = 1'b0;
        #1;
        q_wdata.delete();
        q_pc.delete();
        chk("abort outputs", {26'b0, bus.irq_req, bus.interrupt, bus.return_from_interrupt,
            bus.csr_wr, bus.redirect_valid, bus.busy}, 32'd0);
        chk("abort csr port", {20'b0, bus.csr_addr} | bus.csr_wdata, 32'd0);
        chk("abort redirect_pc", bus.redirect_pc, RPC);
        bus.mip = 32'd0; bus.boundary = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        apply(vecs[0]);
        tick;
        chk("queues drained", q_wdata.size() + q_pc.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer sitting directly upstream of the CSR file. It consumes the CSR file's `mstatus`, `mie`, `mip`, `mtvec` and `mepc` views. From them it decides when a pending interrupt is taken at an instruction boundary, or when an MRET completes. It then drives the CSR file's `interrupt`, `return_from_interrupt` and CSR write port, and redirects fetch to the handler or the return address.

## Interface
- `RESET_PC`, default 32'h0000_0000: `redirect_pc` value out of reset.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `mstatus`  in  mstatus_t  CSR file mstatus view; uses MIE.
- `mie`  in  32  CSR file mie view.
- `mip`  in  32  CSR file mip view.
- `mtvec`  in  mtvec_t  CSR file mtvec view; fields BASE[31:2], MODE[1:0].
- `mepc`  in  32  CSR file mepc view.
- `privilege`  in  privilege_t  current privilege.
- `boundary`  in  1  core holds an instruction at issue that has not executed; its pc is on the CSR file's `pc`.
- `mret`  in  1  instruction at issue is MRET; qualified by `boundary`.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `irq_req`  out  1  asks core to stop issuing and present a boundary.
- `interrupt`  out  1  one-cycle trap-entry pulse to CSR file.
- `return_from_interrupt`  out  1  one-cycle MRET pulse to CSR file.
- `csr_wr`  out  1  CSR write strobe; muxed onto the CSR file write port.
- `csr_addr`  out  12  CSR write address.
- `csr_wdata`  out  32  CSR write data.
- `redirect_valid`  out  1  fetch redirect request.
- `redirect_pc`  out  32  redirect target.
- `busy`  out  1  state ≠ IDLE; core must not retire while high.

## Operation
- Pending vector P = mip & mie, restricted to bits 11 (MEI), 3 (MSI) and 7 (MTI).
- Enable E = mstatus.MIE, or privilege below M.
- Take condition: P ≠ 0 and E.
- Priority is MEI(11) > MSI(3) > MTI(7). The winner's code is latched into a 5-bit `cause` register.
- FSM states: IDLE, ARM, ENTER, CAUSE, REDIR, RET.
- IDLE:
  - If `boundary` and `mret`, go to RET.
  - Otherwise, if the take condition holds, go to ARM.
  - MRET wins a tie, so the interrupt is re-evaluated after the return.
- ARM: `irq_req` = 1.
  - On `boundary`, re-evaluate the take condition.
  - If it is false, return to IDLE (interrupt withdrawn).
  - If it is true, latch `cause` and go to ENTER. A simultaneous `mret` is ignored; that MRET has not executed and is re-issued after the handler.
- ENTER: `interrupt` = 1 for exactly one cycle. The CSR file saves pc into mepc and updates MIE/MPIE/MPP. Next state: CAUSE.
- CAUSE:
  - `csr_wr` = 1, `csr_addr` = 12'h342, `csr_wdata` = {1'b1, 26'b0, cause}.
  - This is a separate cycle because the CSR file ignores writes in a cycle where `interrupt` is high.
  - Next state: REDIR, with `redirect_pc` = handler address.
- REDIR: `redirect_valid` = 1 and `redirect_pc` held stable until `redirect_ready`, then go to IDLE.
- RET:
  - `return_from_interrupt` = 1 for one cycle.
  - `redirect_pc` = {mepc[31:2], 2'b00}, sampled in this cycle.
  - Next state: REDIR.
- Handler address: {mtvec.BASE, 2'b00}. Vectored variant: see Configuration.
- Arithmetic is 32-bit unsigned and wraps modulo 2^32.
- `csr_addr` and `csr_wdata` are 0 whenever `csr_wr` = 0.

## Timing
- Reset values: state IDLE; all strobes 0; `redirect_pc` = RESET_PC; `cause` = 0.
- Reset mid-sequence aborts immediately. No partial CSR write is completed.
- All outputs are registered. They are decoded from the state register plus the `cause` and `redirect_pc` registers.
- Interrupt latency, with the source visible in `mip` at cycle 0 and `boundary` held high:
  - ARM at cycle 1.
  - ENTER at cycle 2 (`interrupt` high).
  - CAUSE at cycle 3.
  - REDIR at cycle 4; `redirect_valid` is first high this cycle.
- MRET latency: RET is the cycle after `boundary` & `mret` are sampled; REDIR follows.
- `redirect_valid` and `redirect_pc` are held with no combinational path from `redirect_ready`.
- New `mip` bits arriving during ENTER/CAUSE/REDIR are not considered until IDLE. MIE is 0 by then, so they are taken only after MRET.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - If mtvec.MODE == 2'b01, handler = {mtvec.BASE, 2'b00} + (cause << 2).
  - MODE 2'b00, 2'b10 and 2'b11 use the direct address.
- Not defined: MODE is ignored, and the handler is always {mtvec.BASE, 2'b00}.

## Structure
- Shared package `instructions` (with mstatus_t, mtvec_t, privilege_t) gains:
  - the cause code constants (CAUSE_MSI = 3, CAUSE_MTI = 7, CAUSE_MEI = 11);
  - CSR_MCAUSE = 12'h342;
  - the `trap_state_t` enum.
- One sub-module, `irq_prio`: combinational priority encoder from P to {valid, cause[4:0]}.

## Test plan
- mip = 1<<7, mie = 1<<7, MIE = 1, mtvec = 32'h100, `boundary` held high:
  - `interrupt` pulse at cycle 2.
  - `csr_wr` to 0x342 with 0x8000_0007 at cycle 3.
  - `redirect_pc` = 0x100.
- mip = mie = 0x888:
  - cause 11, `csr_wdata` = 0x8000_000B.
  - With `TRAP_VECTORED_EN`, mtvec = 0x201, so `redirect_pc` = 0x22C.
- MIE = 0, privilege M, mip = mie = 0x8 → stays IDLE and `irq_req` stays 0. Same stimulus with privilege U → trap taken.
- In ARM, mip bit cleared before `boundary` → back to IDLE; no `interrupt`, no `csr_wr`.
- `boundary` & `mret` with mepc = 0x1236:
  - `return_from_interrupt` pulse.
  - `redirect_pc` = 0x1234.
  - `redirect_valid` held for 3 cycles until `redirect_ready`.
- rst_n asserted in CAUSE → all outputs 0, `redirect_pc` = RESET_PC. After release, normal re-trap.
